psum_acc: RTL and testbench

PSUM_ACC -- requirements
Module: psum_acc

---
 rtl/psum_pkg.sv | 33 +++
 rtl/psum_acc_if.sv | 31 +++
 rtl/psum_fifo2.sv | 62 ++++++
 rtl/psum_acc.sv | 189 ++++++++++++++++++
 tb/tb_psum_acc.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/psum_pkg.sv
// psum_pkg: shared types and constants for the partial-sum accumulator.
//   wsize_e   : kernel-size codes carried on each beat
//   state_e   : round-sequencing FSM states
//   FIFO_DEPTH: depth of the result FIFO
//   rounds_of : number of accumulation rounds for a kernel-size code
package psum_pkg;

  typedef enum logic [1:0] {
    WS_3X3  = 2'd0,
    WS_5X5  = 2'd1,
    WS_7X7  = 2'd2,
    WS_RSVD = 2'd3
  } wsize_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_e;

  localparam int FIFO_DEPTH = 2;

  // Reserved code behaves like 3x3 (single round).
  function automatic logic [2:0] rounds_of(input logic [1:0] ws);
    logic [2:0] r;
    case (wsize_e'(ws))
      WS_5X5:  r = 3'd2;
      WS_7X7:  r = 3'd4;
      default: r = 3'd1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/psum_acc_if.sv
// psum_acc_if: beat input bus and Psum output bus of psum_acc.
//   master modport: the side producing beats and consuming Psum results
//   slave  modport: the accumulator itself
interface psum_acc_if #(
  parameter int CH   = 8,
  parameter int TAPS = 9,
  parameter int PW   = 16,
  parameter int AW   = 24
) ();
  logic [1:0]           wsize;
  logic [1:0]           wround;
  logic [CH*TAPS*PW-1:0] MUL_results;
  logic                 MUL_DATA_valid;
  logic                 MUL_DATA_ready;
  logic                 clear;
  logic [CH*AW-1:0]     Psum;
  logic                 Psum_valid;
  logic                 Psum_ready;
  logic                 wround_err;
  logic                 sat_flag;

  modport master (
    output wsize, wround, MUL_results, MUL_DATA_valid, clear, Psum_ready,
    input  MUL_DATA_ready, Psum, Psum_valid, wround_err, sat_flag
  );

  modport slave (
    input  wsize, wround, MUL_results, MUL_DATA_valid, clear, Psum_ready,
    output MUL_DATA_ready, Psum, Psum_valid, wround_err, sat_flag
  );
endinterface

// File: rtl/psum_fifo2.sv
// psum_fifo2: 2-entry result FIFO with valid/ready output.
//   clk, rst_n : clock, async active-low reset
//   in_valid   : push request (dropped only if full with no pop)
//   in_data    : pushed entry
//   out_valid  : FIFO non-empty
//   out_ready  : consumer accepts head entry
//   out_data   : head entry, held stable until popped
//   count      : current occupancy, used upstream for credit
module psum_fifo2
  import psum_pkg::*;
#(
  parameter int W = 192
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   count
);

  logic [W-1:0] mem_r [FIFO_DEPTH];
  logic         wr_ptr_r;
  logic         rd_ptr_r;
  logic [1:0]   cnt_r;
  logic         push_s;
  logic         pop_s;

  // Handshake decode; a full FIFO still accepts a push when it pops the same cycle.
  always_comb begin
    pop_s  = out_ready && (cnt_r != 2'd0);
    push_s = in_valid && ((cnt_r != 2'(FIFO_DEPTH)) || pop_s);
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= '0;
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      cnt_r    <= 2'd0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= in_data;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (pop_s) rd_ptr_r <= ~rd_ptr_r;
      case ({push_s, pop_s})
        2'b10:   cnt_r <= cnt_r + 2'd1;
        2'b01:   cnt_r <= cnt_r - 2'd1;
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  assign out_valid = (cnt_r != 2'd0);
  assign out_data  = mem_r[rd_ptr_r];
  assign count     = cnt_r;

endmodule

// File: rtl/psum_acc.sv
// psum_acc: two-stage partial-sum accumulator for multi-round convolution kernels.
//   clk, rst_n : clock, async active-low reset
//   bus        : psum_acc_if slave -- beat input (wsize, wround, MUL_results,
//                MUL_DATA_valid/ready, clear), result output (Psum,
//                Psum_valid/ready) and sticky wround_err / sat_flag.
// Stage 1 sums TAPS products per lane; stage 2 accumulates rounds; the final
// round's accumulator is clamped/wrapped to AW bits and pushed into a 2-entry FIFO.
module psum_acc
  import psum_pkg::*;
#(
  parameter int CH   = 8,
  parameter int TAPS = 9,
  parameter int PW   = 16,
  parameter int AW   = 24,
  parameter int SAT  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  psum_acc_if.slave  bus
);

  // Internal width: AW+3, widened if a full 4-round group of extreme products
  // would not otherwise fit, so clamping always sees the true sum.
  localparam int FULLW = PW + $clog2(4 * TAPS) + 1;
  localparam int ACW   = (AW + 3 > FULLW) ? AW + 3 : FULLW;
  localparam logic signed [ACW-1:0] MAXV = {{(ACW-AW+1){1'b0}}, {(AW-1){1'b1}}};
  localparam logic signed [ACW-1:0] MINV = {{(ACW-AW+1){1'b1}}, {(AW-1){1'b0}}};

  state_e                 state_r, state_s;
  logic [1:0]             exp_r;
  logic [2:0]             rounds_r;
  logic                   rdy_en_r;
  logic                   s1_valid_r, s1_first_r, s1_last_r;
  logic signed [ACW-1:0]  s1_sum_r [CH];
  logic                   s2_push_r;
  logic signed [ACW-1:0]  acc_r [CH];
  logic                   err_r, sat_r;

  logic [1:0]             exp_s;
  logic [2:0]             rounds_s;
  logic                   match_s, first_s, last_s, accept_s, beat_ok_s;
  logic                   ready_s;
  logic [1:0]             fifo_cnt_s;
  logic [2:0]             credit_s;
  logic signed [ACW-1:0]  sum_s [CH];
  logic [CH*AW-1:0]       res_s;
  logic                   ovf_s;

  // Credit: FIFO entries plus group results still travelling through stages 1-2.
  always_comb begin
    credit_s = {1'b0, fifo_cnt_s} + {2'b00, s1_valid_r & s1_last_r} + {2'b00, s2_push_r};
    ready_s  = rdy_en_r && (credit_s < 3'd2);
  end

  // FSM outputs: expected round, group length and beat classification.
  always_comb begin
    exp_s     = (state_r == ST_IDLE) ? 2'd0 : exp_r;
    rounds_s  = (state_r == ST_IDLE) ? rounds_of(bus.wsize) : rounds_r;
    first_s   = (state_r == ST_IDLE);
    match_s   = (bus.wround == exp_s);
    last_s    = ({1'b0, exp_s} == (rounds_s - 3'd1));
    accept_s  = bus.MUL_DATA_valid && ready_s && !bus.clear;
    beat_ok_s = accept_s && match_s;
  end

  // FSM next state; clear overrides any beat.
  always_comb begin
    state_s = state_r;
    if (bus.clear) begin
      state_s = ST_IDLE;
    end else if (beat_ok_s) begin
      state_s = last_s ? ST_IDLE : ST_ACCUM;
    end else begin
      state_s = state_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_s;
  end

  // Expected-round counter and group length latched on the round-0 beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_r    <= 2'd0;
      rounds_r <= 3'd1;
    end else if (bus.clear) begin
      exp_r    <= 2'd0;
    end else if (beat_ok_s) begin
      exp_r <= last_s ? 2'd0 : exp_s + 2'd1;
      if (first_s) rounds_r <= rounds_s;
    end
  end

  // Per-lane adder tree over sign-extended products.
  always_comb begin
    for (int c = 0; c < CH; c++) begin
      sum_s[c] = '0;
      for (int t = 0; t < TAPS; t++) begin
        sum_s[c] = sum_s[c] + ACW'(signed'(bus.MUL_results[(c*TAPS+t)*PW +: PW]));
      end
    end
  end

  // Stage 1 register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_first_r <= 1'b0;
      s1_last_r  <= 1'b0;
      for (int c = 0; c < CH; c++) s1_sum_r[c] <= '0;
    end else if (bus.clear) begin
      s1_valid_r <= 1'b0;
    end else begin
      s1_valid_r <= beat_ok_s;
      s1_first_r <= first_s;
      s1_last_r  <= last_s;
      if (beat_ok_s) begin
        for (int c = 0; c < CH; c++) s1_sum_r[c] <= sum_s[c];
      end
    end
  end

  // Stage 2: a round-0 beat restarts the accumulator, later rounds add to it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_push_r <= 1'b0;
      for (int c = 0; c < CH; c++) acc_r[c] <= '0;
    end else if (bus.clear) begin
      s2_push_r <= 1'b0;
      for (int c = 0; c < CH; c++) acc_r[c] <= '0;
    end else begin
      s2_push_r <= s1_valid_r && s1_last_r;
      if (s1_valid_r) begin
        for (int c = 0; c < CH; c++) begin
          acc_r[c] <= (s1_first_r ? '0 : acc_r[c]) + s1_sum_r[c];
        end
      end
    end
  end

  // Range reduction of the finished accumulator to AW-bit lanes.
  always_comb begin
    ovf_s = 1'b0;
    res_s = '0;
    for (int c = 0; c < CH; c++) begin
      if (acc_r[c] > MAXV) begin
        ovf_s = 1'b1;
        res_s[c*AW +: AW] = (SAT != 0) ? MAXV[AW-1:0] : acc_r[c][AW-1:0];
      end else if (acc_r[c] < MINV) begin
        ovf_s = 1'b1;
        res_s[c*AW +: AW] = (SAT != 0) ? MINV[AW-1:0] : acc_r[c][AW-1:0];
      end else begin
        res_s[c*AW +: AW] = acc_r[c][AW-1:0];
      end
    end
  end

  // Sticky status flags and post-reset ready enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r    <= 1'b0;
      sat_r    <= 1'b0;
      rdy_en_r <= 1'b0;
    end else begin
      rdy_en_r <= 1'b1;
      if (accept_s && !match_s) err_r <= 1'b1;
      if (s2_push_r && !bus.clear && ovf_s) sat_r <= 1'b1;
    end
  end

  psum_fifo2 #(.W(CH*AW)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s2_push_r && !bus.clear),
    .in_data   (res_s),
    .out_valid (bus.Psum_valid),
    .out_ready (bus.Psum_ready),
    .out_data  (bus.Psum),
    .count     (fifo_cnt_s)
  );

  assign bus.MUL_DATA_ready = ready_s;
  assign bus.wround_err     = err_r;
  assign bus.sat_flag       = sat_r;

endmodule

// File: tb/tb_psum_acc.sv
// tb_psum_acc: directed self-checking bench for psum_acc. A default-parameter
// instance is scoreboarded (expected Psum vectors queued when the completing
// beat is sent, compared when handed out); an AW=18 saturating instance covers
// clamping.
module tb_psum_acc;

  logic clk;
  logic rst_n;
  int   n_pass, n_fail, n_total;
  logic [255:0] exp_q[$];

  psum_acc_if #(.CH(8), .TAPS(9), .PW(16), .AW(24)) bif ();
  psum_acc_if #(.CH(8), .TAPS(9), .PW(16), .AW(18)) sif ();

  psum_acc #(.CH(8), .TAPS(9), .PW(16), .AW(24), .SAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bif)
  );
  psum_acc #(.CH(8), .TAPS(9), .PW(16), .AW(18), .SAT(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .bus(sif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] lanes(input int v, input int aw);
    logic [255:0] r;
    logic [31:0]  vv;
    r  = '0;
    vv = v;
    for (int c = 0; c < 8; c++) begin
      for (int b = 0; b < aw; b++) r[c*aw+b] = vv[b];
    end
    return r;
  endfunction

  // Scoreboard: compare every Psum handed out against the queued expectation.
  always @(negedge clk) begin
    if (rst_n && bif.Psum_valid && bif.Psum_ready) begin
      if (exp_q.size() == 0) chk("unexpected_psum", 256'(bif.Psum), 256'd0);
      else                   chk("psum", 256'(bif.Psum), exp_q.pop_front());
    end
  end

  task automatic present(input logic [1:0] ws, input logic [1:0] wr, input logic [15:0] v);
    @(posedge clk);
    #1;
    bif.wsize          = ws;
    bif.wround         = wr;
    bif.MUL_results    = {72{v}};
    bif.MUL_DATA_valid = 1'b1;
  endtask

  task automatic take();
    int n;
    n = 0;
    @(negedge clk);
    while (!bif.MUL_DATA_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("accept_timeout", 256'd0, 256'd1);
    @(posedge clk);
    #1;
    bif.MUL_DATA_valid = 1'b0;
  endtask

  task automatic send(input logic [1:0] ws, input logic [1:0] wr, input logic [15:0] v);
    present(ws, wr, v);
    take();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", 256'(exp_q.size()), 256'd0);
  endtask

  initial begin
    n_pass = 0; n_fail = 0; n_total = 0;
    rst_n = 1'b0;
    bif.wsize = 2'd0; bif.wround = 2'd0; bif.MUL_results = '0;
    bif.MUL_DATA_valid = 1'b0; bif.clear = 1'b0; bif.Psum_ready = 1'b0;
    sif.wsize = 2'd0; sif.wround = 2'd0; sif.MUL_results = '0;
    sif.MUL_DATA_valid = 1'b0; sif.clear = 1'b0; sif.Psum_ready = 1'b1;

    // Reset state.
    #12;
    chk("rst_psum_valid", 256'(bif.Psum_valid), 256'd0);
    chk("rst_psum", 256'(bif.Psum), 256'd0);
    chk("rst_ready", 256'(bif.MUL_DATA_ready), 256'd0);
    chk("rst_wround_err", 256'(bif.wround_err), 256'd0);
    chk("rst_sat_flag", 256'(bif.sat_flag), 256'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("ready_after_rst", 256'(bif.MUL_DATA_ready), 256'd1);
    bif.Psum_ready = 1'b1;

    // 3x3 single beat of ones: 9 per lane, valid two edges after acceptance.
    exp_q.push_back(lanes(9, 24));
    send(2'd0, 2'd0, 16'd1);
    @(negedge clk); chk("lat_k0", 256'(bif.Psum_valid), 256'd0);
    @(negedge clk); chk("lat_k1", 256'(bif.Psum_valid), 256'd0);
    @(negedge clk); chk("lat_k2", 256'(bif.Psum_valid), 256'd1);
    drain();

    // 5x5 two rounds: 9*2 + 9*3 = 45.
    send(2'd1, 2'd0, 16'd2);
    exp_q.push_back(lanes(45, 24));
    send(2'd1, 2'd1, 16'd3);
    drain();

    // Round sequence 0,0,1: middle beat dropped, 9*1 + 9*2 = 27.
    chk("err_before", 256'(bif.wround_err), 256'd0);
    send(2'd1, 2'd0, 16'd1);
    send(2'd1, 2'd0, 16'd7);
    @(negedge clk);
    chk("err_after", 256'(bif.wround_err), 256'd1);
    exp_q.push_back(lanes(27, 24));
    send(2'd1, 2'd1, 16'd2);
    drain();

    // Back-pressure: two results fill the credit, third beat stalls until drain.
    @(posedge clk); #1 bif.Psum_ready = 1'b0;
    exp_q.push_back(lanes(9, 24));
    send(2'd0, 2'd0, 16'd1);
    exp_q.push_back(lanes(18, 24));
    send(2'd0, 2'd0, 16'd2);
    exp_q.push_back(lanes(27, 24));
    present(2'd0, 2'd0, 16'd3);
    repeat (4) @(negedge clk);
    chk("ready_low_full", 256'(bif.MUL_DATA_ready), 256'd0);
    @(posedge clk); #1 bif.Psum_ready = 1'b1;
    take();
    drain();

    // Clear after round 1 of a 7x7 group: nothing emitted, next group clean.
    send(2'd2, 2'd0, 16'd1);
    send(2'd2, 2'd1, 16'd1);
    bif.clear = 1'b1;
    @(posedge clk); #1 bif.clear = 1'b0;
    repeat (4) @(negedge clk);
    chk("clear_no_psum", 256'(bif.Psum_valid), 256'd0);
    exp_q.push_back(lanes(9, 24));
    send(2'd0, 2'd0, 16'd1);
    drain();
    chk("main_sat_flag", 256'(bif.sat_flag), 256'd0);

    // Reset after round 1 of a 7x7 group: group discarded.
    send(2'd2, 2'd0, 16'd1);
    send(2'd2, 2'd1, 16'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_no_psum", 256'(bif.Psum_valid), 256'd0);
    exp_q.push_back(lanes(9, 24));
    send(2'd0, 2'd0, 16'd1);
    drain();

    // Saturating instance: 4 rounds of -32768 * 9 taps clamps to -131072.
    chk("sat_flag_before", 256'(sif.sat_flag), 256'd0);
    for (int r = 0; r < 4; r++) begin
      int n;
      @(posedge clk);
      #1;
      sif.wsize          = 2'd2;
      sif.wround         = 2'(r);
      sif.MUL_results    = {72{16'h8000}};
      sif.MUL_DATA_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!sif.MUL_DATA_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (n >= 50) chk("sat_accept_timeout", 256'd0, 256'd1);
      @(posedge clk);
      #1 sif.MUL_DATA_valid = 1'b0;
    end
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (!sif.Psum_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("sat_psum", 256'(sif.Psum), lanes(-131072, 18));
      chk("sat_flag_after", 256'(sif.sat_flag), 256'd1);
    end

    repeat (3) @(negedge clk);
    chk("queue_empty_end", 256'(exp_q.size()), 256'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
